// File: rtl/down_counter_if.sv
// Handshake bundle for the loadable down-counter/timer.
// master drives load/din/en/auto_reload; slave returns q/tc/busy.
interface down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;

    modport master (
        output load,
        output din,
        output en,
        output auto_reload,
        input  q,
        input  tc,
        input  busy
    );

    modport slave (
        input  load,
        input  din,
        input  en,
        input  auto_reload,
        output q,
        output tc,
        output busy
    );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot or auto-reload expiry.
// Ports: clk, rst (async active-low), bus (slave): load/din/en/auto_reload in; q/tc/busy out.
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    down_counter_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             tc_q, tc_d;

    logic             step;
    logic             do_load;
    logic             do_expire;
    logic             do_dec;

    // RUN is only entered with a nonzero load, so q never sits at 0
    // in RUN and the decrement path can never underflow.
    assign step      = (state_q == RUN) && bus.en;
    assign do_load   = bus.load;
    assign do_expire = !bus.load && step && (q_q == ONE);
    assign do_dec    = !bus.load && step && (q_q != ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            q_q      <= ZERO;
            period_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            period_q <= period_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        period_d = period_q;
        tc_d     = 1'b0;
        unique case (1'b1)
            do_load: begin
                q_d      = bus.din;
                period_d = bus.din;
                state_d  = (bus.din != ZERO) ? RUN : IDLE;
            end
            do_expire: begin
                tc_d = 1'b1;
                if (bus.auto_reload) begin
                    q_d = period_q;
                end else begin
                    q_d     = ZERO;
                    state_d = IDLE;
                end
            end
            do_dec: begin
                q_d = q_q - ONE;
            end
            default: ;
        endcase
    end

    assign bus.q    = q_q;
    assign bus.tc   = tc_q;
    assign bus.busy = (state_q == RUN);
endmodule
